// File: rtl/generic_sync_fifo_guarded_pkg.sv
// Shared helpers for the guarded synchronous FIFO: address/count width calculation.
package generic_sync_fifo_guarded_pkg;

    // Smallest r (>= 1) such that 2**r >= value; sizes pointers and the occupancy counter.
    function automatic int clogb2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/generic_sync_fifo_guarded_sdp_ram.sv
// Simple dual-port RAM: synchronous write, one-cycle registered read; only the read register is reset.
module generic_sync_fifo_guarded_sdp_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int SIZE       = 2048,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH-1:0] mem_r [SIZE];

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_r[waddr_i] <= d_i;
        end
    end

    // Read data register; holds its value until the next read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= {DATA_WIDTH{1'b0}};
        end else if (re_i) begin
            q_o <= mem_r[raddr_i];
        end else begin
            q_o <= q_o;
        end
    end

endmodule

// File: rtl/generic_sync_fifo_guarded.sv
// Single-clock FIFO with guarded push/pop, sticky error latches, almost flags and optional show-ahead.
module generic_sync_fifo_guarded
    import generic_sync_fifo_guarded_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int SIZE             = 2048,
    parameter int SHOW_AHEAD       = 0,
    parameter int ALMOST_EMPTY_THR = 10,
    parameter int ALMOST_FULL_THR  = SIZE - 10
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [DATA_WIDTH-1:0]          d_i,
    input  logic                           we_i,
    output logic                           full_o,
    output logic                           almost_full_o,
    input  logic                           rd_i,
    output logic [DATA_WIDTH-1:0]          q_o,
    output logic                           empty_o,
    output logic                           almost_empty_o,
    output logic [clogb2(SIZE+1)-1:0]      count_o,
    output logic                           overflow_o,
    output logic                           underflow_o,
    input  logic                           clr_err_i
);

    localparam int AW = clogb2(SIZE);
    localparam int CW = clogb2(SIZE + 1);
    localparam logic [CW-1:0] SIZE_C   = CW'(SIZE);
    localparam logic [CW-1:0] AE_C     = CW'(ALMOST_EMPTY_THR);
    localparam logic [CW-1:0] AF_C     = CW'(ALMOST_FULL_THR);
    localparam logic [AW-1:0] PTR_LAST = AW'(SIZE - 1);

    if (DATA_WIDTH < 1 || SIZE < 2 || ALMOST_EMPTY_THR < 0 ||
        ALMOST_EMPTY_THR >= ALMOST_FULL_THR || ALMOST_FULL_THR > SIZE) begin : g_bad_params
        $error("generic_sync_fifo_guarded: illegal parameters (need 0 <= AE_THR < AF_THR <= SIZE, SIZE >= 2)");
    end

    logic          wr_acc_s;
    logic          rd_acc_s;
    logic          ram_re_s;
    logic          q_valid_next_s;
    logic [CW-1:0] count_next_s;
    logic [CW-1:0] ram_words_s;
    logic [AW-1:0] wr_ptr_next_s;
    logic [AW-1:0] rd_ptr_next_s;
    logic          full_next_s;
    logic          afull_next_s;
    logic          empty_next_s;
    logic          aempty_next_s;
    logic          ovf_next_s;
    logic          unf_next_s;

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          q_valid_r;
    logic          full_r;
    logic          afull_r;
    logic          empty_r;
    logic          aempty_r;
    logic          ovf_r;
    logic          unf_r;

    // Acceptance, next-state occupancy, pointers, flags and error latches.
    always_comb begin
        wr_acc_s = we_i && !full_r;
        rd_acc_s = rd_i && !empty_r;

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_next_s = count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_next_s = count_r;
        endcase

        // In show-ahead mode count_r includes the word parked in the output register.
        ram_words_s = count_r - {{(CW-1){1'b0}}, q_valid_r};

        if (SHOW_AHEAD != 0) begin
            ram_re_s = (!q_valid_r || rd_acc_s) && (ram_words_s != {CW{1'b0}});
            if (ram_re_s) begin
                q_valid_next_s = 1'b1;
            end else if (rd_acc_s) begin
                q_valid_next_s = 1'b0;
            end else begin
                q_valid_next_s = q_valid_r;
            end
            empty_next_s = !q_valid_next_s;
        end else begin
            ram_re_s       = rd_acc_s;
            q_valid_next_s = 1'b0;
            empty_next_s   = (count_next_s == {CW{1'b0}});
        end

        if (wr_acc_s) begin
            wr_ptr_next_s = (wr_ptr_r == PTR_LAST) ? {AW{1'b0}} : wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        if (ram_re_s) begin
            rd_ptr_next_s = (rd_ptr_r == PTR_LAST) ? {AW{1'b0}} : rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        full_next_s   = (count_next_s == SIZE_C);
        afull_next_s  = (count_next_s >= AF_C);
        aempty_next_s = (count_next_s <= AE_C);

        // A rejection in the same cycle as a clear keeps the flag set.
        if (we_i && full_r) begin
            ovf_next_s = 1'b1;
        end else if (clr_err_i) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end

        if (rd_i && empty_r) begin
            unf_next_s = 1'b1;
        end else if (clr_err_i) begin
            unf_next_s = 1'b0;
        end else begin
            unf_next_s = unf_r;
        end
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            q_valid_r <= 1'b0;
            full_r    <= 1'b0;
            afull_r   <= 1'b0;
            empty_r   <= 1'b1;
            aempty_r  <= 1'b1;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
        end else begin
            wr_ptr_r  <= wr_ptr_next_s;
            rd_ptr_r  <= rd_ptr_next_s;
            count_r   <= count_next_s;
            q_valid_r <= q_valid_next_s;
            full_r    <= full_next_s;
            afull_r   <= afull_next_s;
            empty_r   <= empty_next_s;
            aempty_r  <= aempty_next_s;
            ovf_r     <= ovf_next_s;
            unf_r     <= unf_next_s;
        end
    end

    generic_sync_fifo_guarded_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIZE       (SIZE),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr_acc_s),
        .waddr_i (wr_ptr_r),
        .d_i     (d_i),
        .re_i    (ram_re_s),
        .raddr_i (rd_ptr_r),
        .q_o     (q_o)
    );

    assign full_o         = full_r;
    assign almost_full_o  = afull_r;
    assign empty_o        = empty_r;
    assign almost_empty_o = aempty_r;
    assign count_o        = count_r;
    assign overflow_o     = ovf_r;
    assign underflow_o    = unf_r;

endmodule

// File: tb/tb_generic_sync_fifo_guarded.sv
// Self-checking bench: table-driven standard-mode run, show-ahead and wrap sequences, async reset check.
module tb_generic_sync_fifo_guarded;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Standard mode, SIZE=8, AE=2, AF=6
    logic [15:0] a_d = 16'h0;
    logic a_we = 1'b0, a_rd = 1'b0, a_clr = 1'b0;
    logic a_full, a_af, a_empty, a_ae, a_ovf, a_unf;
    logic [15:0] a_q;
    logic [3:0]  a_cnt;

    // Show-ahead mode, SIZE=8, AE=2, AF=6
    logic [15:0] b_d = 16'h0;
    logic b_we = 1'b0, b_rd = 1'b0, b_clr = 1'b0;
    logic b_full, b_af, b_empty, b_ae, b_ovf, b_unf;
    logic [15:0] b_q;
    logic [3:0]  b_cnt;

    // Standard mode, SIZE=5 (non power of two), AE=1, AF=4
    logic [15:0] c_d = 16'h0;
    logic c_we = 1'b0, c_rd = 1'b0, c_clr = 1'b0;
    logic c_full, c_af, c_empty, c_ae, c_ovf, c_unf;
    logic [15:0] c_q;
    logic [2:0]  c_cnt;

    generic_sync_fifo_guarded #(.DATA_WIDTH(16), .SIZE(8), .SHOW_AHEAD(0),
        .ALMOST_EMPTY_THR(2), .ALMOST_FULL_THR(6)) u_a (
        .clk_i(clk), .rst_i(rst), .d_i(a_d), .we_i(a_we), .full_o(a_full),
        .almost_full_o(a_af), .rd_i(a_rd), .q_o(a_q), .empty_o(a_empty),
        .almost_empty_o(a_ae), .count_o(a_cnt), .overflow_o(a_ovf),
        .underflow_o(a_unf), .clr_err_i(a_clr));

    generic_sync_fifo_guarded #(.DATA_WIDTH(16), .SIZE(8), .SHOW_AHEAD(1),
        .ALMOST_EMPTY_THR(2), .ALMOST_FULL_THR(6)) u_b (
        .clk_i(clk), .rst_i(rst), .d_i(b_d), .we_i(b_we), .full_o(b_full),
        .almost_full_o(b_af), .rd_i(b_rd), .q_o(b_q), .empty_o(b_empty),
        .almost_empty_o(b_ae), .count_o(b_cnt), .overflow_o(b_ovf),
        .underflow_o(b_unf), .clr_err_i(b_clr));

    generic_sync_fifo_guarded #(.DATA_WIDTH(16), .SIZE(5), .SHOW_AHEAD(0),
        .ALMOST_EMPTY_THR(1), .ALMOST_FULL_THR(4)) u_c (
        .clk_i(clk), .rst_i(rst), .d_i(c_d), .we_i(c_we), .full_o(c_full),
        .almost_full_o(c_af), .rd_i(c_rd), .q_o(c_q), .empty_o(c_empty),
        .almost_empty_o(c_ae), .count_o(c_cnt), .overflow_o(c_ovf),
        .underflow_o(c_unf), .clr_err_i(c_clr));

    typedef struct {
        logic        we;
        logic        rd;
        logic        clr;
        logic [15:0] d;
        int          cnt;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic void add(input logic we, input logic rd, input logic clr,
                                input logic [15:0] d, input int cnt,
                                input logic ovf, input logic unf);
        vec_t v;
        v.we = we; v.rd = rd; v.clr = clr; v.d = d; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {full, almost_full, empty, almost_empty, overflow, underflow, count} for the SIZE=8 instances
    function automatic logic [9:0] exp_status(input int cnt, input logic ovf, input logic unf);
        logic [3:0] c4;
        c4 = 4'(cnt);
        return {(cnt == 8), (cnt >= 6), (cnt == 0), (cnt <= 2), ovf, unf, c4};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        prev_full;
        logic        prev_empty;
        logic [15:0] exp_q;

        // Fill, overflow, clear, full drain, underflow, and simultaneous rd+wr at both extremes.
        for (int i = 1; i <= 8; i++) add(1'b1, 1'b0, 1'b0, 16'(i), i, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 16'h0009, 8, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 8, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) add(1'b0, 1'b1, 1'b0, 16'h0000, 8 - i, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 16'h0000, 0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 16'h0020, 1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 1, 1'b0, 1'b0);
        for (int i = 2; i <= 8; i++) add(1'b1, 1'b0, 1'b0, 16'(16'h0020 + i - 1), i, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 16'h0099, 7, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 16'h0000, 6, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 6, 1'b0, 1'b0);

        #12;
        check("reset status", {a_full, a_af, a_empty, a_ae, a_ovf, a_unf, a_cnt}, exp_status(0, 1'b0, 1'b0));
        check("reset q", a_q, 16'h0000);
        rst = 1'b0;
        tick();

        prev_full  = 1'b0;
        prev_empty = 1'b1;
        exp_q      = 16'h0000;
        for (int i = 0; i < tbl.size(); i++) begin
            a_we = tbl[i].we; a_rd = tbl[i].rd; a_clr = tbl[i].clr; a_d = tbl[i].d;
            if (tbl[i].rd && !prev_empty) exp_q = sb.pop_front();
            if (tbl[i].we && !prev_full) sb.push_back(tbl[i].d);
            tick();
            check($sformatf("row%0d status", i), {a_full, a_af, a_empty, a_ae, a_ovf, a_unf, a_cnt},
                  exp_status(tbl[i].cnt, tbl[i].ovf, tbl[i].unf));
            check($sformatf("row%0d q", i), a_q, exp_q);
            prev_full  = (tbl[i].cnt == 8);
            prev_empty = (tbl[i].cnt == 0);
        end
        a_we = 1'b0; a_rd = 1'b0; a_clr = 1'b0;

        // Reach count 5 with overflow set, then assert reset between clock edges.
        a_we = 1'b1; a_d = 16'h0077;
        repeat (3) tick();
        a_we = 1'b0; a_rd = 1'b1;
        repeat (3) tick();
        a_rd = 1'b0;
        check("pre-reset status", {a_full, a_af, a_empty, a_ae, a_ovf, a_unf, a_cnt}, exp_status(5, 1'b1, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        check("async reset status", {a_full, a_af, a_empty, a_ae, a_ovf, a_unf, a_cnt}, exp_status(0, 1'b0, 1'b0));
        check("async reset q", a_q, 16'h0000);
        tick();
        rst = 1'b0;
        sb.delete();

        a_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_d = 16'(16'h0100 + i);
            tick();
        end
        a_clr = 1'b1;
        tick();
        check("clr vs rejected write", {a_full, a_ovf, a_cnt}, {1'b1, 1'b1, 4'd8});
        a_we = 1'b0;
        tick();
        check("clr alone", {a_full, a_ovf, a_cnt}, {1'b1, 1'b0, 4'd8});
        a_clr = 1'b0;

        // Show-ahead: first-word fall-through latency and pops.
        b_we = 1'b1; b_d = 16'hA5A5;
        tick();
        check("sa write N", {b_empty, b_cnt}, {1'b1, 4'd1});
        b_we = 1'b0;
        tick();
        check("sa N+1 q", b_q, 16'hA5A5);
        check("sa N+1 empty", {b_empty, b_cnt}, {1'b0, 4'd1});
        b_we = 1'b1; b_d = 16'h5A5A;
        tick();
        check("sa second write", {b_q, b_empty, b_cnt}, {16'hA5A5, 1'b0, 4'd2});
        b_we = 1'b0; b_rd = 1'b1;
        tick();
        check("sa pop1", {b_q, b_empty, b_cnt}, {16'h5A5A, 1'b0, 4'd1});
        tick();
        check("sa pop2", {b_empty, b_cnt, b_unf}, {1'b1, 4'd0, 1'b0});
        tick();
        check("sa pop at empty", {b_empty, b_cnt, b_unf}, {1'b1, 4'd0, 1'b1});
        b_rd = 1'b0; b_clr = 1'b1;
        tick();
        check("sa clr", b_unf, 1'b0);
        b_clr = 1'b0;

        // Show-ahead: back-to-back pops at one word per cycle.
        b_we = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            b_d = 16'(16'h0101 * k);
            sb.push_back(b_d);
            tick();
        end
        b_we = 1'b0;
        tick();
        check("sa b2b head", {b_q, b_empty, b_cnt}, {sb[0], 1'b0, 4'd3});
        b_rd = 1'b1;
        for (int k = 0; k < 3; k++) begin
            void'(sb.pop_front());
            tick();
            if (sb.size() != 0) check($sformatf("sa b2b pop%0d", k), {b_q, b_empty}, {sb[0], 1'b0});
            else                check($sformatf("sa b2b pop%0d", k), {b_empty, b_cnt}, {1'b1, 4'd0});
        end
        b_rd = 1'b0;

        // SIZE=5: interleaved write/read pairs through several pointer wraps.
        for (int i = 0; i < 23; i++) begin
            c_we = 1'b1; c_d = 16'(16'h0300 + i);
            sb.push_back(c_d);
            tick();
            check($sformatf("wrap%0d cnt1", i), {c_cnt, c_empty}, {3'd1, 1'b0});
            c_we = 1'b0; c_rd = 1'b1;
            tick();
            check($sformatf("wrap%0d q", i), {c_q, c_cnt, c_empty}, {sb.pop_front(), 3'd0, 1'b1});
            c_rd = 1'b0;
        end
        check("wrap errors", {c_ovf, c_unf}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
